// File: rtl/fcmp_arbiter.sv
// Shared single-precision FEQ/FLT/FLE unit with a two-port round-robin front end,
// one registered result stage and a sticky invalid-operation flag for fflags.
module fcmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_nv,
  output logic             flag_nv,
  input  logic             flag_clr
);

  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic             prio_q, prio_d;
  logic             rspValid_q, rspValid_d;
  logic             rspId_q, rspId_d;
  logic [WIDTH-1:0] rspData_q, rspData_d;
  logic             rspNv_q, rspNv_d;
  logic             flagNv_q, flagNv_d;

  logic             free, grant0, grant1, accept;
  logic [1:0]       selOp;
  logic [WIDTH-1:0] selA, selB;
  logic             aNan, bNan, aSnan, bSnan, anyNan;
  logic             bothZero, isEq, isLt, cmpBit, nvBit;

  // The grant depends only on valids, prio and the result slot, never on operands.
  always_comb begin
    free   = !rspValid_q || rsp_ready;
    grant0 = req0_valid && (!req1_valid || !prio_q);
    grant1 = req1_valid && (!req0_valid ||  prio_q);
    accept = free && (grant0 || grant1);
  end

  assign req0_ready = free && grant0;
  assign req1_ready = free && grant1;

  always_comb begin
    selOp = grant1 ? req1_op : req0_op;
    selA  = grant1 ? req1_a  : req0_a;
    selB  = grant1 ? req1_b  : req0_b;
  end

  // Sign-magnitude ordering; both zeros are equal regardless of sign, subnormals by raw bits.
  always_comb begin
    aNan     = (selA[30:23] == 8'hFF) && (selA[22:0] != 23'd0);
    bNan     = (selB[30:23] == 8'hFF) && (selB[22:0] != 23'd0);
    aSnan    = aNan && !selA[22];
    bSnan    = bNan && !selB[22];
    anyNan   = aNan || bNan;
    bothZero = (selA[30:0] == 31'd0) && (selB[30:0] == 31'd0);
    isEq     = bothZero || (selA == selB);
    if (bothZero) begin
      isLt = 1'b0;
    end else if (selA[31] != selB[31]) begin
      isLt = selA[31];
    end else if (!selA[31]) begin
      isLt = selA[30:0] < selB[30:0];
    end else begin
      isLt = selA[30:0] > selB[30:0];
    end
    if (selOp == OP_FLT) begin
      cmpBit = !anyNan && isLt;
      nvBit  = anyNan;
    end else if (selOp == OP_FLE) begin
      cmpBit = !anyNan && (isLt || isEq);
      nvBit  = anyNan;
    end else begin
      cmpBit = !anyNan && isEq;
      nvBit  = aSnan || bSnan;
    end
  end

  always_comb begin
    prio_d     = prio_q;
    rspValid_d = rspValid_q;
    rspId_d    = rspId_q;
    rspData_d  = rspData_q;
    rspNv_d    = rspNv_q;
    if (free) begin
      rspValid_d = accept;
    end
    if (accept) begin
      prio_d    = grant0;
      rspId_d   = grant1;
      rspData_d = {{(WIDTH-1){1'b0}}, cmpBit};
      rspNv_d   = nvBit;
    end
    // A set in the same cycle as a clear must win.
    if (accept && nvBit) begin
      flagNv_d = 1'b1;
    end else if (flag_clr) begin
      flagNv_d = 1'b0;
    end else begin
      flagNv_d = flagNv_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rspValid_q <= 1'b0;
      rspId_q    <= 1'b0;
      rspData_q  <= '0;
      rspNv_q    <= 1'b0;
      flagNv_q   <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspData_q  <= rspData_d;
      rspNv_q    <= rspNv_d;
      flagNv_q   <= flagNv_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;
  assign rsp_nv    = rspNv_q;
  assign flag_nv   = flagNv_q;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter: arbitration order, compare semantics,
// back-pressure, sticky NV flag and asynchronous reset, all against hand-computed values.
module tb_fcmp_arbiter;

  localparam logic [1:0] FEQ = 2'b00;
  localparam logic [1:0] FLT = 2'b01;
  localparam logic [1:0] FLE = 2'b10;

  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] SNAN = 32'h7F800001;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_nv, flag_nv, flag_clr;
  logic [31:0] rsp_data;

  int vecCount  = 0;
  int missCount = 0;

  fcmp_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_nv(rsp_nv),
    .flag_nv(flag_nv), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-port request: checks the ready lines, takes one edge, then withdraws.
  task automatic applyStimulus(input bit port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    checkOutput("single_ready0", {31'd0, req0_ready}, {31'd0, !port});
    checkOutput("single_ready1", {31'd0, req1_ready}, {31'd0, port});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic checkRsp(input string tag, input logic id, input logic data, input logic nv);
    checkOutput({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    checkOutput({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    checkOutput({tag, "_data"},  rsp_data,           {31'd0, data});
    checkOutput({tag, "_nv"},    {31'd0, rsp_nv},    {31'd0, nv});
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; rsp_ready = 1'b1; flag_clr = 1'b0;
    req0_valid = 1'b0; req0_op = FEQ; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = FEQ; req1_a = '0; req1_b = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_id",    {31'd0, rsp_id},    32'd0);
    checkOutput("reset_data",  rsp_data,           32'd0);
    checkOutput("reset_nv",    {31'd0, rsp_nv},    32'd0);
    checkOutput("reset_flag",  {31'd0, flag_nv},   32'd0);
    #9 rst_n = 1'b1;
    tick();

    // 1.0 < 2.0 on port 0
    applyStimulus(1'b0, FLT, ONE, TWO);
    checkRsp("flt_basic", 1'b0, 1'b1, 1'b0);

    // prio now points at port 1; port 0 FEQ(1,1)=1, port 1 FLT(2,1)=0
    req0_valid = 1'b1; req0_op = FEQ; req0_a = ONE; req0_b = ONE;
    req1_valid = 1'b1; req1_op = FLT; req1_a = TWO; req1_b = ONE;
    for (int i = 0; i < 4; i++) begin
      logic expId;
      expId = (i % 2 == 0);
      #1;
      checkOutput("rr_ready0", {31'd0, req0_ready}, {31'd0, !expId});
      checkOutput("rr_ready1", {31'd0, req1_ready}, {31'd0, expId});
      tick();
      checkRsp("rr_rsp", expId, !expId, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checkOutput("idle_valid", {31'd0, rsp_valid}, 32'd0);

    applyStimulus(1'b0, FEQ, 32'h80000000, 32'h00000000);
    checkRsp("feq_zero", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, FEQ, QNAN, ONE);
    checkRsp("feq_qnan", 1'b0, 1'b0, 1'b0);
    checkOutput("flag_after_feq_qnan", {31'd0, flag_nv}, 32'd0);
    applyStimulus(1'b0, FLE, QNAN, ONE);
    checkRsp("fle_qnan", 1'b0, 1'b0, 1'b1);
    checkOutput("flag_after_fle_qnan", {31'd0, flag_nv}, 32'd1);
    applyStimulus(1'b1, FLT, 32'hC0000000, 32'hBF800000);
    checkRsp("flt_neg", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, FLE, 32'h00000002, 32'h00000001);
    checkRsp("fle_subnorm", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, FLT, 32'h80000000, 32'h00000000);
    checkRsp("flt_zero", 1'b0, 1'b0, 1'b0);

    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("flag_cleared", {31'd0, flag_nv}, 32'd0);

    // Back-pressure: prio points at port 1 after the last port-0 grant
    applyStimulus(1'b0, FLT, ONE, TWO);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = FEQ; req0_a = ONE; req0_b = ONE;
    req1_valid = 1'b1; req1_op = FLT; req1_a = TWO; req1_b = ONE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_ready0", {31'd0, req0_ready}, 32'd0);
      checkOutput("bp_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      checkRsp("bp_hold", 1'b0, 1'b1, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready0", {31'd0, req0_ready}, 32'd0);
    checkOutput("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkRsp("bp_release", 1'b1, 1'b0, 1'b0);

    // Clear and set collide: set wins
    flag_clr = 1'b1;
    applyStimulus(1'b0, FEQ, SNAN, ONE);
    checkRsp("feq_snan", 1'b0, 1'b0, 1'b1);
    checkOutput("flag_set_wins", {31'd0, flag_nv}, 32'd1);
    tick();
    flag_clr = 1'b0;
    checkOutput("flag_clr_alone", {31'd0, flag_nv}, 32'd0);

    // Port 0 grant leaves prio at 1; reset must bring it back to 0
    applyStimulus(1'b0, FLT, QNAN, ONE);
    checkRsp("pre_reset", 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("async_reset_flag",  {31'd0, flag_nv},   32'd0);
    #10 rst_n = 1'b1;
    tick();
    req0_valid = 1'b1; req0_op = FEQ; req0_a = ONE; req0_b = ONE;
    req1_valid = 1'b1; req1_op = FLT; req1_a = TWO; req1_b = ONE;
    #1;
    checkOutput("post_reset_ready0", {31'd0, req0_ready}, 32'd1);
    checkOutput("post_reset_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkRsp("post_reset", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
